// File: rtl/conv_out_pkg.sv
// conv_out_pkg: shared types and constant helpers for the convolution
// output-feature-map writer.
//   state_t  - writer FSM states
//   plane()  - words per channel plane (OUT_W*OUT_H)
//   cnt_w()  - counter width for a 0..max-1 counter
//   sat_hi() / sat_lo() - signed storage limits for a given word width
package conv_out_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int OFM_DATA_W = 16;

  function automatic int plane(input int w, input int h);
    return w * h;
  endfunction

  function automatic int cnt_w(input int max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

  function automatic longint sat_hi(input int dw);
    return (longint'(1) << (dw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

  localparam longint SAT_HI = sat_hi(OFM_DATA_W);
  localparam longint SAT_LO = sat_lo(OFM_DATA_W);

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-MAX up counter.
//   clk, rst - clock, synchronous active-high reset
//   clr      - synchronous clear to 0
//   en       - advance by one
//   cnt      - current count, 0..MAX-1
//   wrap     - combinational: en while cnt is at MAX-1
module wrap_counter
  import conv_out_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [cnt_w(MAX)-1:0] cnt,
  output logic                  wrap
);

  localparam int W = cnt_w(MAX);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  assign wrap = (cnt == LAST) && en;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/conv_ofmap_writer.sv
// conv_ofmap_writer: write-back end of the convolution datapath.
// Accepts channel-fastest accumulator results, saturates (and optionally
// rectifies) them, and writes them channel-planar (C,H,W) from base_addr.
//   start/base_addr/relu_en - begin a volume (honoured only when idle)
//   in_valid/in_data/in_ready - accumulator result stream
//   mem_we/mem_addr/mem_wdata - registered memory write port
//   busy - not idle; done - one-cycle volume-complete pulse
module conv_ofmap_writer
  import conv_out_pkg::*;
#(
  parameter int OUT_W  = 6,
  parameter int OUT_H  = 6,
  parameter int OUT_C  = 4,
  parameter int ACC_W  = 32,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              relu_en,
  input  logic              in_valid,
  input  logic [ACC_W-1:0]  in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam int PLANE = plane(OUT_W, OUT_H);
  localparam int CH_W  = cnt_w(OUT_C);
  localparam int COL_W = cnt_w(OUT_W);
  localparam int ROW_W = cnt_w(OUT_H);

  localparam logic [ADDR_W-1:0] PLANE_A = ADDR_W'(PLANE);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(OUT_C - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(OUT_H - 1);

  localparam logic signed [ACC_W-1:0]  HI_A = ACC_W'(sat_hi(DATA_W));
  localparam logic signed [ACC_W-1:0]  LO_A = ACC_W'(sat_lo(DATA_W));
  localparam logic signed [DATA_W-1:0] HI_D = DATA_W'(sat_hi(DATA_W));
  localparam logic signed [DATA_W-1:0] LO_D = DATA_W'(sat_lo(DATA_W));

  function automatic logic signed [DATA_W-1:0] sat_relu(
    input logic signed [ACC_W-1:0] x,
    input logic                    relu
  );
    logic signed [DATA_W-1:0] y;
    if (x > HI_A)      y = HI_D;
    else if (x < LO_A) y = LO_D;
    else               y = x[DATA_W-1:0];
    if (relu && y[DATA_W-1]) y = '0;
    return y;
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] base_lat;
  logic              relu_lat;

  logic [ADDR_W-1:0] ch_off;
  logic [ADDR_W-1:0] pos;

  logic [CH_W-1:0]   ch_cnt;
  logic [COL_W-1:0]  col_cnt;
  logic [ROW_W-1:0]  row_cnt;
  logic              ch_wrap;
  logic              col_wrap;
  logic              row_wrap;

  logic              acc;
  logic              start_acc;
  logic              last;

  logic                     vld_p1;
  logic [ADDR_W-1:0]        addr_p1;
  logic signed [DATA_W-1:0] wdata_p1;

  assign acc       = in_valid && in_ready;
  assign start_acc = start && (state == IDLE);
  assign last      = acc && (ch_cnt == CH_LAST) && (col_cnt == COL_LAST) &&
                     (row_cnt == ROW_LAST);

  wrap_counter #(.MAX(OUT_C)) u_ch (
    .clk(clk), .rst(rst), .clr(start_acc), .en(acc),
    .cnt(ch_cnt), .wrap(ch_wrap)
  );

  wrap_counter #(.MAX(OUT_W)) u_col (
    .clk(clk), .rst(rst), .clr(start_acc), .en(ch_wrap),
    .cnt(col_cnt), .wrap(col_wrap)
  );

  wrap_counter #(.MAX(OUT_H)) u_row (
    .clk(clk), .rst(rst), .clr(start_acc), .en(col_wrap),
    .cnt(row_cnt), .wrap(row_wrap)
  );

  // Control FSM; in_ready/busy/done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      base_lat <= '0;
      relu_lat <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            base_lat <= base_addr;
            relu_lat <= relu_en;
          end
        end
        RUN: begin
          if (last) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          state <= FIN;
          done  <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Incremental address terms: ch_off = ch*PLANE, pos = row*OUT_W + col.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      ch_off <= '0;
      pos    <= '0;
    end else if (acc) begin
      ch_off <= ch_wrap ? '0 : ch_off + PLANE_A;
      if (row_wrap)     pos <= '0;
      else if (ch_wrap) pos <= pos + ADDR_W'(1);
    end
  end

  // ---- stage p1: registered memory write ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= acc;
      if (acc) begin
        addr_p1  <= base_lat + ch_off + pos;
        wdata_p1 <= sat_relu(in_data, relu_lat);
      end
    end
  end

  assign mem_we    = vld_p1;
  assign mem_addr  = addr_p1;
  assign mem_wdata = wdata_p1;

endmodule

// File: tb/tb_conv_ofmap_writer.sv
// tb_conv_ofmap_writer: directed self-checking bench for conv_ofmap_writer
// at default parameters (6x6x4 volume, 16-bit words, 10-bit addresses).
module tb_conv_ofmap_writer;

  localparam int NBEATS = 144;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic        relu_en;
  logic        in_valid;
  logic signed [31:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;

  conv_ofmap_writer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .relu_en(relu_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_bad = 0;

  int w_addr[$];
  int w_data[$];
  int w_cyc[$];
  int a_cyc[$];
  int d_cyc[$];
  int data_q[NBEATS];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      w_addr.push_back(int'(mem_addr));
      w_data.push_back(int'($signed(mem_wdata)));
      w_cyc.push_back(cyc);
    end
    if (in_valid && in_ready) a_cyc.push_back(cyc);
    if (done) d_cyc.push_back(cyc);
  end

  always @(negedge clk) begin
    if (in_ready && (!busy || done)) ready_bad <= ready_bad + 1;
  end

  function automatic int exp_addr(input int base, input int i);
    return (base + (i % 4) * 36 + i / 4) % 1024;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    a_cyc.delete(); d_cyc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int base, input bit relu);
    start = 1'b1; base_addr = 10'(base); relu_en = relu;
    tick(1);
    start = 1'b0;
    chk("ready_after_start", in_ready, 1);
  endtask

  // Feeds data_q[from..to-1]; gaps inserts random idle cycles.
  task automatic send(input int from, input int to, input bit gaps);
    int i = from;
    int guard = 0;
    bit v;
    bit a;
    while (i < to && guard < 4000) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data  = data_q[i];
      a = v && in_ready;
      tick(1);
      guard++;
      if (a) i++;
    end
    in_valid = 1'b0;
    chk("send_accepted", i, to);
  endtask

  task automatic check_tail(input string tag);
    chk({tag, "_drain_we"}, mem_we, 1);
    chk({tag, "_drain_rdy"}, in_ready, 0);
    chk({tag, "_drain_busy"}, busy, 1);
    tick(1);
    chk({tag, "_done"}, done, 1);
    tick(1);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_done"}, done, 0);
  endtask

  task automatic check_volume(input string tag, input int base);
    int bad_a = 0;
    int bad_d = 0;
    int bad_t = 0;
    chk({tag, "_writes"}, w_addr.size(), NBEATS);
    chk({tag, "_accepts"}, a_cyc.size(), NBEATS);
    if (w_addr.size() == NBEATS && a_cyc.size() == NBEATS) begin
      for (int i = 0; i < NBEATS; i++) begin
        if (w_addr[i] != exp_addr(base, i)) bad_a++;
        if (w_data[i] != data_q[i]) bad_d++;
        if (w_cyc[i] != a_cyc[i] + 1) bad_t++;
      end
      chk({tag, "_addr_errs"}, bad_a, 0);
      chk({tag, "_data_errs"}, bad_d, 0);
      chk({tag, "_lat_errs"}, bad_t, 0);
      chk({tag, "_done_n"}, d_cyc.size(), 1);
      if (d_cyc.size() == 1) chk({tag, "_done_cyc"}, d_cyc[0], a_cyc[NBEATS-1] + 2);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; relu_en = 1'b0;
    in_valid = 1'b0; in_data = '0;
    tick(3);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    in_valid = 1'b1;
    tick(2);
    chk("idle_no_write", w_addr.size(), 0);
    in_valid = 1'b0;

    // Test 1: streaming volume, data = beat index
    for (int i = 0; i < NBEATS; i++) data_q[i] = i;
    clear_logs();
    do_start(0, 1'b0);
    send(0, NBEATS, 1'b0);
    check_tail("t1");
    check_volume("t1", 0);
    if (w_addr.size() >= 5) begin
      chk("t1_a1", w_addr[1], 36);
      chk("t1_a3", w_addr[3], 108);
      chk("t1_a4", w_addr[4], 1);
    end
    if (w_addr.size() == NBEATS) chk("t1_a143", w_addr[143], 143);

    // Test 2: saturation without and with ReLU
    for (int i = 0; i < NBEATS; i++) data_q[i] = 0;
    data_q[0] = 40000; data_q[1] = -40000; data_q[2] = -5; data_q[3] = 7;
    clear_logs();
    do_start(0, 1'b0);
    send(0, NBEATS, 1'b0);
    tick(3);
    if (w_data.size() >= 4) begin
      chk("t2_pos_sat", w_data[0], 32767);
      chk("t2_neg_sat", w_data[1], -32768);
      chk("t2_neg_pass", w_data[2], -5);
      chk("t2_pos_pass", w_data[3], 7);
    end else chk("t2_writes", w_data.size(), NBEATS);
    clear_logs();
    do_start(0, 1'b1);
    send(0, NBEATS, 1'b0);
    tick(3);
    if (w_data.size() >= 4) begin
      chk("t2r_pos_sat", w_data[0], 32767);
      chk("t2r_neg_sat", w_data[1], 0);
      chk("t2r_neg", w_data[2], 0);
      chk("t2r_pos", w_data[3], 7);
    end else chk("t2r_writes", w_data.size(), NBEATS);

    // Test 3: random gaps in in_valid
    for (int i = 0; i < NBEATS; i++) data_q[i] = 3 * i - 200;
    clear_logs();
    do_start(0, 1'b0);
    send(0, NBEATS, 1'b1);
    check_tail("t3");
    check_volume("t3", 0);

    // Test 4: address wrap from base 1000
    for (int i = 0; i < NBEATS; i++) data_q[i] = i;
    clear_logs();
    do_start(1000, 1'b0);
    send(0, NBEATS, 1'b0);
    tick(3);
    check_volume("t4", 1000);
    if (w_addr.size() >= 5) begin
      chk("t4_a0", w_addr[0], 1000);
      chk("t4_a1", w_addr[1], 12);
      chk("t4_a2", w_addr[2], 48);
      chk("t4_a3", w_addr[3], 84);
      chk("t4_a4", w_addr[4], 1001);
    end

    // Test 5: reset after 50 accepts, then restart
    clear_logs();
    do_start(200, 1'b0);
    send(0, 50, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_we", mem_we, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", in_ready, 0);
    tick(10);
    chk("t5_no_done", d_cyc.size(), 0);
    chk("t5_writes", w_addr.size(), 50);
    clear_logs();
    data_q[0] = 123;
    do_start(300, 1'b0);
    send(0, 1, 1'b0);
    tick(1);
    if (w_addr.size() == 1) begin
      chk("t5_restart_addr", w_addr[0], 300);
      chk("t5_restart_data", w_data[0], 123);
    end else chk("t5_restart_writes", w_addr.size(), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;

    // Test 6: stray starts during RUN and on the done cycle
    for (int i = 0; i < NBEATS; i++) data_q[i] = NBEATS - i;
    clear_logs();
    do_start(0, 1'b0);
    send(0, 20, 1'b0);
    start = 1'b1; base_addr = 10'd500; relu_en = 1'b1;
    tick(1);
    start = 1'b0;
    send(20, NBEATS, 1'b0);
    tick(1);
    chk("t6_done_cycle", done, 1);
    start = 1'b1; base_addr = 10'd700;
    tick(1);
    start = 1'b0;
    chk("t6_start_on_done_busy", busy, 0);
    tick(1);
    chk("t6_still_idle", busy, 0);
    chk("t6_still_not_ready", in_ready, 0);
    check_volume("t6", 0);
    clear_logs();
    do_start(5, 1'b0);
    send(0, NBEATS, 1'b0);
    tick(3);
    check_volume("t6b", 5);

    chk("ready_outside_run", ready_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_ofmap_writer.md
# conv_ofmap_writer

Write-back end of the 3D convolution datapath. Takes accumulated convolution results from the MAC array over a valid/ready stream, in channel-fastest order: all output channels for one (row, col) position, then the next column, then the next row. Each result is saturated to the storage width and optionally rectified. The block writes it into the output feature-map memory in channel-planar (C, H, W) layout starting at a base address, and signals completion of a full output volume.

## Interface
- OUT_W, 6, output feature-map width (columns)
- OUT_H, 6, output feature-map height (rows)
- OUT_C, 4, output channels
- ACC_W, 32, signed accumulator input width
- DATA_W, 16, signed stored word width
- ADDR_W, 10, memory address width

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a new output volume; honoured only in IDLE
- base_addr  in  ADDR_W  volume base address, sampled on accepted start
- relu_en  in  1  rectification enable, sampled on accepted start
- in_valid  in  1  result beat valid
- in_data  in  ACC_W  signed accumulator result
- in_ready  out  1  block accepts a beat
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, volume complete

## Operation
- Counters:
  - ch: 0..OUT_C-1, increments on every accepted beat.
  - col: 0..OUT_W-1, increments when ch wraps.
  - row: 0..OUT_H-1, increments when col wraps.
- Address is base + ch*PLANE + row*OUT_W + col, with PLANE = OUT_W*OUT_H. It is computed incrementally with no multiplier:
  - ch_off adds PLANE on each ch increment and clears on ch wrap.
  - pos increments on ch wrap.
- Address sum is modulo 2^ADDR_W; wrap is silent.
- Data path:
  - Signed clamp of in_data to [-(2^(DATA_W-1)), 2^(DATA_W-1)-1].
  - If relu_en is latched, negative results become 0.
- FSM states:
  - IDLE: in_ready=0. start → RUN; latch base_addr and relu_en, clear all counters.
  - RUN: in_ready=1. Accept when in_valid && in_ready. Accepting the last beat (ch=OUT_C-1, col=OUT_W-1, row=OUT_H-1) → DRAIN.
  - DRAIN: in_ready=0. The registered final write is on the bus this cycle. → FIN.
  - FIN: done=1 → IDLE.
- start outside IDLE is ignored. in_valid outside RUN is never accepted and causes no write.
- Total beats per volume: OUT_W*OUT_H*OUT_C.

## Timing
- Reset: all outputs 0, state IDLE, counters and latched base/relu 0. rst mid-volume aborts immediately: no further writes, no done pulse.
- start sampled high at edge t (in IDLE): in_ready=1 from cycle t+1.
- Beat accepted at edge k: mem_we=1 with its mem_addr/mem_wdata during cycle k+1, i.e. one-cycle registered latency. Otherwise mem_we=0; addr/wdata hold their last value.
- Back-to-back beats give one write per cycle. Gaps in in_valid produce gaps in mem_we with no address skipped.
- Last beat accepted at edge T: DRAIN with final mem_we in cycle T+1, done=1 in cycle T+2, IDLE and busy=0 from cycle T+3.
- Earliest next start is sampled in IDLE at edge T+3.

## Structure
- Package conv_out_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, FIN);
  - a PLANE constant function of OUT_W and OUT_H;
  - saturation limit constants derived from DATA_W.
- Sub-module wrap_counter (parameter MAX; inputs clk, rst, clr, en; outputs cnt, wrap), instantiated three times for ch, col and row.
  - wrap is combinational: cnt==MAX-1 && en.
- Saturation/ReLU stays inline before the output register.

## Test plan
1. Defaults, base_addr=0, relu_en=0, in_valid held high, in_data = beat index 0..143:
   - writes go to addresses 0,36,72,108,1,37,73,109,2,… with wdata equal to the index;
   - beat 143 is written to address 143;
   - done pulses exactly 2 cycles after the last accept, and 144 writes total.
2. Saturation:
   - in_data 40000 → 32767, and -40000 → -32768 with relu_en=0;
   - with relu_en=1: -5 → 0, 7 → 7, 40000 → 32767.
3. in_valid toggled pseudo-randomly:
   - mem_we follows each accept by exactly one cycle;
   - the address sequence is identical to test 1;
   - in_ready is never high in IDLE, DRAIN or FIN.
4. base_addr=1000, ADDR_W=10:
   - first writes at 1000, 12 (1036 mod 1024), 48, 84, then 1001.
5. rst after 50 accepts:
   - next cycle mem_we=0, busy=0, done never pulses;
   - a new start writes its first beat at base+0.
6. start pulsed during RUN and on the done cycle: ignored, counters unaffected. A start in IDLE after done begins a clean second volume.
